// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus command and FSM state encodings
package mem_bus_arbiter_pkg;

    typedef logic [1:0] mem_cmd_t;

    localparam mem_cmd_t MNONE  = 2'b00;
    localparam mem_cmd_t MREAD  = 2'b01;
    localparam mem_cmd_t MWRITE = 2'b10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester handshakes and memory bus of the arbiter
interface mem_bus_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    import mem_bus_arbiter_pkg::*;

    logic              req0;
    mem_cmd_t          cmd0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;

    logic              req1;
    mem_cmd_t          cmd1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    mem_cmd_t          mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              busy;

    modport master (
        output req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, read_data,
        input  ack0, ack1, rdata, mem_cmd, mem_addr, write_data, busy
    );

    modport slave (
        input  req0, cmd0, addr0, wdata0, req1, cmd1, addr1, wdata1, read_data,
        output ack0, ack1, rdata, mem_cmd, mem_addr, write_data, busy
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rtl/mem_bus_arbiter_rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;
    // On a tie the port that did not win last time goes first
    assign gnt_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin arbiter sequencing the shared memory bus
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_arbiter_if.slave bus
);

    logic [2:0]        state;
    logic              lat_id;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              last_grant;

    logic              gnt_valid;
    logic              gnt_id;
    mem_cmd_t          sel_cmd;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_cmd = gnt_id ? bus.cmd1 : bus.cmd0;

    // The latched command lives on in the state encoding itself
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_id     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        lat_id     <= gnt_id;
                        lat_addr   <= gnt_id ? bus.addr1  : bus.addr0;
                        lat_wdata  <= gnt_id ? bus.wdata1 : bus.wdata0;
                        last_grant <= gnt_id;
                        case (sel_cmd)
                            MWRITE:  state <= S_WR;
                            MREAD:   state <= S_RD1;
                            default: state <= S_DONE;
                        endcase
                    end
                end
                S_WR:  state <= S_DONE;
                S_RD1: state <= S_RD2;
                S_RD2: begin
                    rdata_q <= bus.read_data;
                    state   <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RD2 keeps MREAD asserted so the RAM's read driver stays enabled for the capture
    always_comb begin
        bus.mem_cmd = MNONE;
        case (state)
            S_WR:          bus.mem_cmd = MWRITE;
            S_RD1, S_RD2:  bus.mem_cmd = MREAD;
            default:       bus.mem_cmd = MNONE;
        endcase
    end

    assign bus.mem_addr   = lat_addr;
    assign bus.write_data = lat_wdata;
    assign bus.rdata      = rdata_q;
    assign bus.ack0       = (state == S_DONE) && !lat_id;
    assign bus.ack1       = (state == S_DONE) &&  lat_id;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] mem [0:511];
    logic [15:0] mem_q = '0;

    mem_bus_arbiter_if #(.DATA_W(16), .ADDR_W(9)) bus ();

    mem_bus_arbiter #(.DATA_W(16), .ADDR_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_cmd == MREAD)  mem_q <= mem[bus.mem_addr];
        if (bus.mem_cmd == MWRITE) mem[bus.mem_addr] <= bus.write_data;
    end

    assign bus.read_data = (bus.mem_cmd == MREAD) ? mem_q : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h005] = 16'h1234;
        mem[9'h010] = 16'h1111;
        mem[9'h020] = 16'h2222;

        reset = 1'b1;
        bus.req0 = 1'b0; bus.cmd0 = MNONE; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.cmd1 = MNONE; bus.addr1 = '0; bus.wdata1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_cmd", 32'(bus.mem_cmd), 32'h0);
        check("rst_ack0",    32'(bus.ack0),    32'h0);
        check("rst_ack1",    32'(bus.ack1),    32'h0);
        check("rst_busy",    32'(bus.busy),    32'h0);
        check("rst_rdata",   32'(bus.rdata),   32'h0);
        check("rst_addr",    32'(bus.mem_addr), 32'h0);

        // single write from port 0
        reset = 1'b0;
        bus.req0 = 1'b1; bus.cmd0 = MWRITE; bus.addr0 = 9'h100; bus.wdata0 = 16'h00A5;
        @(negedge clk);
        check("wr_cmd",   32'(bus.mem_cmd),    32'h2);
        check("wr_addr",  32'(bus.mem_addr),   32'h100);
        check("wr_data",  32'(bus.write_data), 32'h00A5);
        check("wr_ack0_early", 32'(bus.ack0),  32'h0);
        bus.addr0 = 9'h1FF; bus.wdata0 = 16'hFFFF; bus.cmd0 = MREAD;
        @(negedge clk);
        check("wr_done_cmd", 32'(bus.mem_cmd),  32'h0);
        check("wr_ack0",     32'(bus.ack0),     32'h1);
        check("wr_ack1",     32'(bus.ack1),     32'h0);
        check("wr_addr_hold", 32'(bus.mem_addr), 32'h100);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("wr_idle_ack0", 32'(bus.ack0), 32'h0);
        check("wr_idle_busy", 32'(bus.busy), 32'h0);
        check("wr_mem",       32'(mem[9'h100]), 32'h00A5);

        // single read from port 1
        bus.req1 = 1'b1; bus.cmd1 = MREAD; bus.addr1 = 9'h005;
        @(negedge clk);
        check("rd_rd1_cmd",  32'(bus.mem_cmd),  32'h1);
        check("rd_rd1_addr", 32'(bus.mem_addr), 32'h005);
        @(negedge clk);
        check("rd_rd2_cmd",  32'(bus.mem_cmd),  32'h1);
        check("rd_rd2_ack1", 32'(bus.ack1),     32'h0);
        @(negedge clk);
        check("rd_ack1",  32'(bus.ack1),    32'h1);
        check("rd_ack0",  32'(bus.ack0),    32'h0);
        check("rd_rdata", 32'(bus.rdata),   32'h1234);
        check("rd_done_cmd", 32'(bus.mem_cmd), 32'h0);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("rd_rdata_hold", 32'(bus.rdata), 32'h1234);
        check("rd_idle_ack1",  32'(bus.ack1),  32'h0);

        // contention after reset: grants alternate starting with port 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.req0 = 1'b1; bus.cmd0 = MREAD; bus.addr0 = 9'h010;
        bus.req1 = 1'b1; bus.cmd1 = MREAD; bus.addr1 = 9'h020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ct_rd1_cmd",  32'(bus.mem_cmd),  32'h1);
            check("ct_rd1_addr", 32'(bus.mem_addr), (k % 2 == 0) ? 32'h010 : 32'h020);
            @(negedge clk);
            check("ct_rd2_cmd",  32'(bus.mem_cmd),  32'h1);
            @(negedge clk);
            check("ct_ack0",  32'(bus.ack0),  (k % 2 == 0) ? 32'h1 : 32'h0);
            check("ct_ack1",  32'(bus.ack1),  (k % 2 == 0) ? 32'h0 : 32'h1);
            check("ct_rdata", 32'(bus.rdata), (k % 2 == 0) ? 32'h1111 : 32'h2222);
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            @(negedge clk);
            check("ct_idle_busy", 32'(bus.busy), 32'h0);
            check("ct_idle_acks", 32'({bus.ack1, bus.ack0}), 32'h0);
        end

        // NOP from port 0
        bus.req0 = 1'b1; bus.cmd0 = MNONE; bus.addr0 = 9'h0AA;
        @(negedge clk);
        check("nop_ack0", 32'(bus.ack0),    32'h1);
        check("nop_cmd",  32'(bus.mem_cmd), 32'h0);
        check("nop_busy", 32'(bus.busy),    32'h1);
        check("nop_rdata", 32'(bus.rdata),  32'h2222);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("nop_idle_ack0", 32'(bus.ack0),    32'h0);
        check("nop_idle_cmd",  32'(bus.mem_cmd), 32'h0);

        // reset during RD2 aborts the read without an ack
        bus.req1 = 1'b1; bus.cmd1 = MREAD; bus.addr1 = 9'h010;
        @(negedge clk);
        check("ab_rd1_cmd", 32'(bus.mem_cmd), 32'h1);
        @(negedge clk);
        check("ab_rd2_cmd", 32'(bus.mem_cmd), 32'h1);
        reset = 1'b1;
        bus.req1 = 1'b0;
        @(negedge clk);
        check("ab_cmd",   32'(bus.mem_cmd), 32'h0);
        check("ab_ack1",  32'(bus.ack1),    32'h0);
        check("ab_busy",  32'(bus.busy),    32'h0);
        check("ab_rdata", 32'(bus.rdata),   32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("ab_after_ack1", 32'(bus.ack1), 32'h0);
        check("ab_after_busy", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory bus between two requesters: port 0 (cpu) and port 1 (loader/DMA engine). The bus carries mem_cmd, mem_addr, write data and tri-state read data, and feeds the RAM and the memory-mapped LEDR/SW I/O.
- Sequences each access with a small FSM that accounts for the RAM's one-cycle registered read latency.
- Uses round-robin fairness and returns a one-cycle ack pulse with captured read data to the winning requester.

Parameters:
- DATA_W, 16, data width of wdata/rdata/bus data.
- ADDR_W, 9, memory address width (bit 8 selects I/O space downstream).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- req0  in  1  port-0 request, held high until ack0.
- cmd0  in  2  port-0 command: MREAD=2'b01, MWRITE=2'b10.
- addr0  in  ADDR_W  port-0 address.
- wdata0  in  DATA_W  port-0 write data.
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, cmd1, addr1, wdata1, ack1  same as port 0, for port 1.
- rdata  out  DATA_W  captured read data, valid in the ack cycle.
- mem_cmd  out  2  bus command: MNONE=2'b00, MREAD, MWRITE.
- mem_addr  out  ADDR_W  bus address.
- write_data  out  DATA_W  bus write data.
- read_data  in  DATA_W  bus read data (tri-state-resolved, valid while mem_cmd=MREAD on the cycle after the address is presented).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset state: IDLE.
  - mem_cmd=MNONE, mem_addr=0, write_data=0, rdata=0.
  - ack0=ack1=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE, WR, RD1, RD2, DONE.
- Arbitration happens in IDLE only.
  - If only one req is high, that port wins.
  - If both are high, the port != last_grant wins.
  - On the edge: latch the winner's id, cmd, addr and wdata into registers and set last_grant := winner.
- Bus outputs are driven solely from the latched registers; requester inputs may change after the grant without effect.
- IDLE transitions:
  - Latched cmd MWRITE -> WR.
  - Latched cmd MREAD -> RD1.
  - Latched cmd 00 or 11 -> DONE (NOP: no bus activity, ack still given).
  - No req -> stay in IDLE.
- WR: mem_cmd=MWRITE for exactly one cycle -> DONE.
- RD1: mem_cmd=MREAD (RAM samples the address at the end of this cycle) -> RD2.
- RD2: mem_cmd=MREAD still held so the tri-state driver stays enabled; rdata := read_data at the end of this cycle -> DONE.
- DONE:
  - mem_cmd=MNONE; ack of the latched port=1 for exactly one cycle.
  - rdata holds its value until the next read capture.
  - Writes and NOPs do not modify rdata.
  - Next state is IDLE; req inputs are ignored in DONE.
- Latency from the req-sampling edge to ack: write 2 cycles, read 3 cycles, NOP 1 cycle.
- Back-to-back: a requester that keeps req high after ack is arbitrated again in the next IDLE cycle. The minimum period per transaction is therefore ack + 1 idle cycle.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1.
- ack0 and ack1 are never high together.
- mem_cmd is never MREAD and MWRITE in the same cycle.
- reset asserted in any state: the next edge forces IDLE and reset values.
  - No ack is issued for the aborted transaction.
  - mem_cmd=MNONE on the following cycle.
- mem_addr and write_data retain their last latched values in IDLE/DONE; downstream decodes gate on mem_cmd.

Decomposition:
- Shared package/header holds:
  - MNONE/MREAD/MWRITE command encodings, matching the existing defines.
  - State encodings IDLE/WR/RD1/RD2/DONE (3-bit).
- One sub-module: rr_arb2, combinational two-way round-robin pick.
  - Inputs: req0, req1, last_grant.
  - Outputs: gnt_valid, gnt_id.
- FSM, latches and ack generation stay in mem_bus_arbiter.

Test Plan:
- Reset: hold reset 2 cycles -> mem_cmd=00, ack0=ack1=0, busy=0, rdata=0.
- Single write: req0=1, cmd0=10, addr0=0x100, wdata0=0x00A5.
  - Exactly one cycle with mem_cmd=10, mem_addr=0x100, write_data=0x00A5.
  - ack0 two cycles after the sampling edge.
- Single read: req1=1, cmd1=01, addr1=0x005, memory model returns 0x1234 one cycle after the address.
  - mem_cmd=01 for two consecutive cycles; ack1 on the third cycle with rdata=0x1234.
- Contention: req0 and req1 both held high with reads to 0x010 and 0x020 after reset.
  - Grant order 0,1,0,1 (mem_addr 0x010,0x020,0x010,0x020); the acks never overlap.
- NOP and abort:
  - cmd0=00 -> ack0 one cycle later with mem_cmd=00 throughout.
  - Separately, reset asserted during RD2 -> no ack, mem_cmd=00 next cycle, IDLE.
